// File: rtl/fm_rx_pkg.sv
// fm_rx_pkg: FSM state type, derived datapath widths and a width-parametrised
// saturation helper shared by the FM discriminator.
package fm_rx_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   function automatic int prod_w(input int iq_w);
      return 2 * iq_w;
   endfunction
   function automatic int disc_w(input int iq_w);
      return 2 * iq_w + 1;
   endfunction
   function automatic int acc_w(input int iq_w, input int decim);
      return 2 * iq_w + 1 + $clog2(decim);
   endfunction
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction
endpackage

// File: rtl/fm_demod_stream_if.sv
// fm_demod_stream_if: AXI-Stream data/valid/ready bundle with master/slave views.
interface fm_demod_stream_if #(parameter int W = 16);
   logic [W-1:0] TDATA;
   logic         TVALID;
   logic         TREADY;
   modport master(output TDATA, output TVALID, input TREADY);
   modport slave(input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/fm_peak_meter.sv
// fm_peak_meter: tracks the peak |audio| of handshaken samples and drives a
// thermometer LED bar; the most negative sample counts as full scale.
module fm_peak_meter #(
   parameter int AUD_W    = 16,
   parameter int NUM_LEDS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clr,
   input  logic                i_vld,
   input  logic [AUD_W-1:0]    i_data,
   output logic [NUM_LEDS-1:0] o_led
);
   logic [AUD_W-1:0] r_peak;
   logic [AUD_W-1:0] w_mag, w_abs;

   assign w_mag = i_data[AUD_W-1] ? AUD_W'(-i_data) : i_data;
   assign w_abs = w_mag[AUD_W-1] ? {1'b0, {(AUD_W-1){1'b1}}} : w_mag;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) r_peak <= '0;
      else if (i_vld && w_abs > r_peak) r_peak <= w_abs;
   end

   for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
      assign o_led[k] = r_peak >= (AUD_W'(1) << (AUD_W - 1 - NUM_LEDS + k));
   end
endmodule

// File: rtl/fm_demod_stream.sv
// fm_demod_stream: streaming cross-product FM discriminator with integrate-and-dump
// decimation, saturating audio output, ap_start/ap_done framing and a peak LED meter.
module fm_demod_stream
   import fm_rx_pkg::*;
#(
   parameter int IQ_W     = 16,
   parameter int AUD_W    = 16,
   parameter int DECIM    = 4,
   parameter int NUM_LEDS = 4
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                ap_start,
   output logic                ap_done,
   output logic                ap_idle,
   output logic                ap_ready,
   input  logic [15:0]         cfg_frame_len,
   input  logic [5:0]          cfg_shift,
   input  logic                cfg_mute,
   fm_demod_stream_if.slave    iq_in_V,
   fm_demod_stream_if.master   audio_out_V,
   output logic [NUM_LEDS-1:0] led_out_V
);
   localparam int PROD_W = prod_w(IQ_W);
   localparam int DISC_W = disc_w(IQ_W);
   localparam int ACC_W  = acc_w(IQ_W, DECIM);
   localparam int CNT_W  = $clog2(DECIM);

   state_t                   r_state;
   logic signed [IQ_W-1:0]   r_ip, r_qp;
   logic signed [PROD_W-1:0] r_p1, r_p2;
   logic                     r_v1, r_mute, r_avld;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic [15:0]              r_ocnt, r_len;
   logic [5:0]               r_shift;
   logic [AUD_W-1:0]         r_aud;

   logic signed [IQ_W-1:0]   w_i, w_q;
   logic signed [DISC_W-1:0] w_d;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [63:0]       w_sat;
   logic                     w_start, w_in_hs, w_out_hs, w_last_in, w_dump;

   assign w_i       = iq_in_V.TDATA[IQ_W-1:0];
   assign w_q       = iq_in_V.TDATA[2*IQ_W-1:IQ_W];
   assign w_start   = r_state == S_IDLE && ap_start;
   assign w_in_hs   = iq_in_V.TVALID && iq_in_V.TREADY;
   assign w_out_hs  = r_avld && audio_out_V.TREADY;
   assign w_d       = DISC_W'(r_p1) - DISC_W'(r_p2);
   assign w_sum     = r_acc + ACC_W'(w_d);
   assign w_sat     = saturate(64'(w_sum >>> r_shift), AUD_W);
   assign w_last_in = r_cnt == CNT_W'(DECIM - 1);
   assign w_dump    = r_v1 && w_last_in && r_state == S_RUN;

   // Input stalls only while a finished sample is waiting on the output.
   assign iq_in_V.TREADY     = r_state == S_RUN && !(r_avld && !audio_out_V.TREADY);
   assign audio_out_V.TDATA  = r_aud;
   assign audio_out_V.TVALID = r_avld;
   assign ap_idle            = r_state == S_IDLE;
   assign ap_done            = r_state == S_DONE;
   assign ap_ready           = r_state == S_DONE;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state <= S_IDLE;
         r_ip    <= '0;
         r_qp    <= '0;
         r_p1    <= '0;
         r_p2    <= '0;
         r_v1    <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ocnt  <= '0;
         r_len   <= 16'd1;
         r_shift <= '0;
         r_mute  <= 1'b0;
         r_aud   <= '0;
         r_avld  <= 1'b0;
      end else begin
         r_v1 <= w_in_hs;
         if (w_in_hs) begin
            r_p1 <= PROD_W'(r_ip) * PROD_W'(w_q);
            r_p2 <= PROD_W'(r_qp) * PROD_W'(w_i);
            r_ip <= w_i;
            r_qp <= w_q;
         end
         if (r_v1 && r_state == S_RUN) begin
            r_acc <= w_last_in ? '0 : w_sum;
            r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
         end
         if (w_dump) begin
            r_aud  <= r_mute ? '0 : AUD_W'(w_sat);
            r_avld <= 1'b1;
         end else if (w_out_hs) r_avld <= 1'b0;
         if (w_out_hs) r_ocnt <= r_ocnt + 1'b1;
         case (r_state)
            S_IDLE: if (ap_start) begin
               r_state <= S_RUN;
               r_len   <= cfg_frame_len == 16'd0 ? 16'd1 : cfg_frame_len;
               r_shift <= cfg_shift;
               r_mute  <= cfg_mute;
               r_ip    <= '0;
               r_qp    <= '0;
               r_v1    <= 1'b0;
               r_acc   <= '0;
               r_cnt   <= '0;
               r_ocnt  <= '0;
            end
            S_RUN:   if (w_out_hs && r_ocnt == r_len - 16'd1) r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   fm_peak_meter #(.AUD_W(AUD_W), .NUM_LEDS(NUM_LEDS)) u_peak (
      .i_clk   (ap_clk),
      .i_rst_n (ap_rst_n),
      .i_clr   (w_start),
      .i_vld   (w_out_hs),
      .i_data  (r_aud),
      .o_led   (led_out_V)
   );
endmodule
